// File: rtl/modexp_sequencer_if.sv
// Control bundle between the modexp sequencer, the precompute block and the shared Montgomery multiplier.
// The slave side is the sequencer; the master side is whoever drives requests and completions.
interface modexp_sequencer_if #(
    parameter int EXP_BITS = 1024,
    parameter int IDX_W    = $clog2(EXP_BITS)
);
    logic                start;
    logic [EXP_BITS-1:0] exp;
    logic                busy;
    logic                done;
    logic                error;
    logic                pre_start;
    logic                pre_done;
    logic                mm_start;
    logic [1:0]          mm_opa_sel;
    logic [1:0]          mm_opb_sel;
    logic                mm_dst_sel;
    logic                mm_done;
    logic [IDX_W:0]      sq_cnt;
    logic [IDX_W:0]      mul_cnt;

    modport slave (
        input  start, exp, pre_done, mm_done,
        output busy, done, error, pre_start, mm_start,
               mm_opa_sel, mm_opb_sel, mm_dst_sel, sq_cnt, mul_cnt
    );

    modport master (
        output start, exp, pre_done, mm_done,
        input  busy, done, error, pre_start, mm_start,
               mm_opa_sel, mm_opb_sel, mm_dst_sel, sq_cnt, mul_cnt
    );
endinterface

// File: rtl/modexp_sequencer.sv
// Left-to-right square-and-multiply sequencer for a shared Montgomery multiplier; issues selects only.
// One cycle from accepted start to pre_start, one cycle from the final mm_done to done; waits abort after TIMEOUT cycles.
module modexp_sequencer #(
    parameter int EXP_BITS = 1024,
    parameter int TIMEOUT  = 4096,
    parameter int IDX_W    = $clog2(EXP_BITS)
) (
    input  logic               clk,
    input  logic               rst,
    modexp_sequencer_if.slave  bus
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_TOMONT, S_INIT, S_SCAN, S_SQ, S_MUL, S_NEXT, S_FROMM, S_FIN
    } state_t;

    typedef enum logic [2:0] {OP_TOMONT, OP_INIT, OP_SQ, OP_MUL, OP_FROMM} op_t;

    state_t              r_state, w_state_nxt;
    logic [EXP_BITS-1:0] r_exp, w_exp_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [TMO_W-1:0]    r_tmo, w_tmo_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_error, w_error_nxt;
    logic                r_pre_start, w_pre_start_nxt;
    logic                r_mm_start, w_mm_start_nxt;
    logic [1:0]          r_opa, w_opa_nxt;
    logic [1:0]          r_opb, w_opb_nxt;
    logic                r_dst, w_dst_nxt;
    logic [IDX_W:0]      r_sq_cnt, w_sq_cnt_nxt;
    logic [IDX_W:0]      r_mul_cnt, w_mul_cnt_nxt;

    logic                w_ack;
    logic                w_wait;
    logic                w_issue;
    op_t                 w_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_exp       <= '0;
            r_idx       <= '0;
            r_tmo       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_pre_start <= 1'b0;
            r_mm_start  <= 1'b0;
            r_opa       <= 2'd0;
            r_opb       <= 2'd0;
            r_dst       <= 1'b0;
            r_sq_cnt    <= '0;
            r_mul_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_exp       <= w_exp_nxt;
            r_idx       <= w_idx_nxt;
            r_tmo       <= w_tmo_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_error     <= w_error_nxt;
            r_pre_start <= w_pre_start_nxt;
            r_mm_start  <= w_mm_start_nxt;
            r_opa       <= w_opa_nxt;
            r_opb       <= w_opb_nxt;
            r_dst       <= w_dst_nxt;
            r_sq_cnt    <= w_sq_cnt_nxt;
            r_mul_cnt   <= w_mul_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_exp_nxt       = r_exp;
        w_idx_nxt       = r_idx;
        w_tmo_nxt       = r_tmo;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_error_nxt     = r_error;
        w_pre_start_nxt = 1'b0;
        w_mm_start_nxt  = 1'b0;
        w_opa_nxt       = r_opa;
        w_opb_nxt       = r_opb;
        w_dst_nxt       = r_dst;
        w_sq_cnt_nxt    = r_sq_cnt;
        w_mul_cnt_nxt   = r_mul_cnt;
        w_issue         = 1'b0;
        w_op            = OP_FROMM;

        // A completion in the same cycle as its own request pulse is not a real completion.
        if (r_state == S_PRE) begin
            w_ack = !r_pre_start && bus.pre_done;
        end else begin
            w_ack = !r_mm_start && bus.mm_done;
        end
        w_wait = (r_state == S_PRE) || (r_state == S_TOMONT) || (r_state == S_INIT) ||
                 (r_state == S_SQ) || (r_state == S_MUL) || (r_state == S_FROMM);

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_exp_nxt       = bus.exp;
                    w_idx_nxt       = IDX_W'(EXP_BITS - 1);
                    w_sq_cnt_nxt    = '0;
                    w_mul_cnt_nxt   = '0;
                    w_error_nxt     = 1'b0;
                    w_busy_nxt      = 1'b1;
                    w_pre_start_nxt = 1'b1;
                    w_tmo_nxt       = '0;
                    w_state_nxt     = S_PRE;
                end
            end
            S_PRE: begin
                if (w_ack) begin
                    w_issue     = 1'b1;
                    w_op        = OP_TOMONT;
                    w_state_nxt = S_TOMONT;
                end
            end
            S_TOMONT: begin
                if (w_ack) begin
                    w_issue     = 1'b1;
                    w_op        = OP_INIT;
                    w_state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                if (w_ack) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                // A zero exponent leaves ACC = R mod n, which converts out to 1.
                if (r_exp == '0) begin
                    w_issue     = 1'b1;
                    w_op        = OP_FROMM;
                    w_state_nxt = S_FROMM;
                end else if (r_exp[EXP_BITS-1]) begin
                    w_issue     = 1'b1;
                    w_op        = OP_MUL;
                    w_state_nxt = S_MUL;
                end else begin
                    w_exp_nxt = {r_exp[EXP_BITS-2:0], 1'b0};
                    w_idx_nxt = r_idx - 1'b1;
                end
            end
            S_SQ: begin
                if (w_ack) begin
                    if (r_exp[EXP_BITS-1]) begin
                        w_issue     = 1'b1;
                        w_op        = OP_MUL;
                        w_state_nxt = S_MUL;
                    end else begin
                        w_state_nxt = S_NEXT;
                    end
                end
            end
            S_MUL: begin
                if (w_ack) begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                if (r_idx == '0) begin
                    w_issue     = 1'b1;
                    w_op        = OP_FROMM;
                    w_state_nxt = S_FROMM;
                end else begin
                    w_exp_nxt   = {r_exp[EXP_BITS-2:0], 1'b0};
                    w_idx_nxt   = r_idx - 1'b1;
                    w_issue     = 1'b1;
                    w_op        = OP_SQ;
                    w_state_nxt = S_SQ;
                end
            end
            S_FROMM: begin
                if (w_ack) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_issue) begin
            w_mm_start_nxt = 1'b1;
            w_tmo_nxt      = '0;
            case (w_op)
                OP_TOMONT: begin w_opa_nxt = 2'd1; w_opb_nxt = 2'd1; w_dst_nxt = 1'b1; end
                OP_INIT:   begin w_opa_nxt = 2'd3; w_opb_nxt = 2'd1; w_dst_nxt = 1'b0; end
                OP_SQ: begin
                    w_opa_nxt = 2'd0; w_opb_nxt = 2'd0; w_dst_nxt = 1'b0;
                    if (r_sq_cnt != '1) w_sq_cnt_nxt = r_sq_cnt + 1'b1;
                end
                OP_MUL: begin
                    w_opa_nxt = 2'd0; w_opb_nxt = 2'd2; w_dst_nxt = 1'b0;
                    if (r_mul_cnt != '1) w_mul_cnt_nxt = r_mul_cnt + 1'b1;
                end
                default:   begin w_opa_nxt = 2'd0; w_opb_nxt = 2'd3; w_dst_nxt = 1'b0; end
            endcase
        end

        // The request pulse cycle also counts toward the wait budget.
        if (w_wait && !w_ack) begin
            if (r_tmo == TMO_LIM) begin
                w_done_nxt  = 1'b1;
                w_error_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end else begin
                w_tmo_nxt = r_tmo + 1'b1;
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.error      = r_error;
    assign bus.pre_start  = r_pre_start;
    assign bus.mm_start   = r_mm_start;
    assign bus.mm_opa_sel = r_opa;
    assign bus.mm_opb_sel = r_opb;
    assign bus.mm_dst_sel = r_dst;
    assign bus.sq_cnt     = r_sq_cnt;
    assign bus.mul_cnt    = r_mul_cnt;
endmodule

// File: tb/tb_modexp_sequencer.sv
// Drives the sequencer against a behavioural Montgomery multiplier and precompute model on a 64-bit modulus,
// comparing op order, counters, flags and the final ACC with a plain modular exponentiation.
module tb_modexp_sequencer;
    localparam int EXP_BITS = 1024;
    localparam int TIMEOUT  = 64;
    localparam int IDX_W    = $clog2(EXP_BITS);

    localparam logic [4:0] OPC_TOMONT = 5'b01_01_1;
    localparam logic [4:0] OPC_INIT   = 5'b11_01_0;
    localparam logic [4:0] OPC_SQ     = 5'b00_00_0;
    localparam logic [4:0] OPC_MUL    = 5'b00_10_0;
    localparam logic [4:0] OPC_FROMM  = 5'b00_11_0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    modexp_sequencer_if #(.EXP_BITS(EXP_BITS), .IDX_W(IDX_W)) bus ();

    modexp_sequencer #(.EXP_BITS(EXP_BITS), .TIMEOUT(TIMEOUT), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Model state
    logic [63:0] n_mod, x_val, acc, xm, t_val, r2_val;
    int          lat_min = 1, lat_max = 1, hold_idx = -1;
    logic [4:0]  op_log[$];
    int          op_cnt, resp_cnt, pre_issues, done_cnt, cyc = 0, hold_cyc, done_cyc;
    bit          pend, pre_pend, sel_bad, multi_bad, done_busy_bad;
    int          pend_cnt, pre_cnt;
    logic [1:0]  pa, pb;
    logic        pd, done_err;
    logic        mm_done_m = 1'b0, pre_done_m = 1'b0, stray_mm = 1'b0, stray_pre = 1'b0;

    assign bus.mm_done  = mm_done_m | stray_mm;
    assign bus.pre_done = pre_done_m | stray_pre;

    function automatic logic [63:0] montmul(input logic [63:0] a, input logic [63:0] b);
        logic [129:0] t;
        t = 130'(a) * 130'(b);
        for (int i = 0; i < 64; i++) begin
            if (t[0]) t = t + 130'(n_mod);
            t = t >> 1;
        end
        if (t >= 130'(n_mod)) t = t - 130'(n_mod);
        return t[63:0];
    endfunction

    function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        p = (128'(a) * 128'(b)) % 128'(n_mod);
        return p[63:0];
    endfunction

    function automatic logic [63:0] ref_modexp(input logic [63:0] x, input logic [EXP_BITS-1:0] e);
        logic [63:0] r;
        r = 64'd1;
        for (int i = EXP_BITS - 1; i >= 0; i--) begin
            r = mulmod(r, r);
            if (e[i]) r = mulmod(r, x);
        end
        return r;
    endfunction

    function automatic logic [63:0] opa_val(input logic [1:0] s);
        case (s)
            2'd0: return acc;
            2'd1: return x_val;
            2'd2: return xm;
            default: return 64'd1;
        endcase
    endfunction

    function automatic logic [63:0] opb_val(input logic [1:0] s);
        case (s)
            2'd0: return acc;
            2'd1: return t_val;
            2'd2: return xm;
            default: return 64'd1;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [63:0] res;
        cyc++;
        mm_done_m  = 1'b0;
        pre_done_m = 1'b0;
        if (rst) begin
            pend     = 1'b0;
            pre_pend = 1'b0;
        end else begin
            if (bus.done) begin
                done_cnt++;
                done_err = bus.error;
                done_cyc = cyc;
                if (bus.busy) done_busy_bad = 1'b1;
            end
            if (pre_pend) begin
                pre_cnt--;
                if (pre_cnt == 0) begin
                    pre_pend   = 1'b0;
                    pre_done_m = 1'b1;
                    t_val      = r2_val;
                end
            end
            if (bus.pre_start) begin
                pre_issues++;
                pre_pend = 1'b1;
                pre_cnt  = $urandom_range(lat_max, lat_min);
            end
            if (pend) begin
                if (bus.mm_opa_sel !== pa || bus.mm_opb_sel !== pb || bus.mm_dst_sel !== pd)
                    sel_bad = 1'b1;
                pend_cnt--;
                if (pend_cnt == 0) begin
                    pend      = 1'b0;
                    mm_done_m = 1'b1;
                    resp_cnt++;
                    res = montmul(opa_val(pa), opb_val(pb));
                    if (pd) xm = res;
                    else    acc = res;
                end
            end
            if (bus.mm_start) begin
                if (pend) multi_bad = 1'b1;
                pa = bus.mm_opa_sel;
                pb = bus.mm_opb_sel;
                pd = bus.mm_dst_sel;
                op_log.push_back({pa, pb, pd});
                if (op_cnt == hold_idx) begin
                    hold_cyc = cyc;
                end else begin
                    pend     = 1'b1;
                    pend_cnt = $urandom_range(lat_max, lat_min);
                end
                op_cnt++;
            end
        end
    end

    task automatic clear_model();
        logic [127:0] rm;
        n_mod  = {1'b1, 31'($urandom), 32'($urandom)} | 64'd1;
        x_val  = {$urandom, $urandom} % n_mod;
        rm     = (128'd1 << 64) % 128'(n_mod);
        r2_val = mulmod(rm[63:0], rm[63:0]);
        acc = '0; xm = '0; t_val = '0;
        op_log.delete();
        op_cnt = 0; resp_cnt = 0; done_cnt = 0;
        sel_bad = 1'b0; multi_bad = 1'b0; done_busy_bad = 1'b0;
    endtask

    task automatic run_case(input string tag, input logic [EXP_BITS-1:0] e,
                            input bit want_tmo, input bit repulse);
        logic [4:0] want_ops[$];
        bit         found;
        int         msb, k;
        clear_model();
        found = 1'b0;
        msb   = 0;
        want_ops.push_back(OPC_TOMONT);
        want_ops.push_back(OPC_INIT);
        for (int i = EXP_BITS - 1; i >= 0; i--) begin
            if (!found) begin
                if (e[i]) begin
                    found = 1'b1;
                    msb   = i;
                    want_ops.push_back(OPC_MUL);
                end
            end else begin
                want_ops.push_back(OPC_SQ);
                if (e[i]) want_ops.push_back(OPC_MUL);
            end
        end
        want_ops.push_back(OPC_FROMM);

        @(negedge clk);
        bus.start = 1'b1;
        bus.exp   = e;
        @(negedge clk);
        bus.start = 1'b0;
        bus.exp   = '0;
        k = 0;
        while (done_cnt == 0 && k < 20000) begin
            @(negedge clk);
            k++;
            if (repulse) begin
                bus.start = (k == 8 || k == 40);
                bus.exp   = {EXP_BITS{1'b1}};
            end
        end
        bus.start = 1'b0;
        repeat (3) @(negedge clk);

        check_eq({tag, " done pulse count"}, done_cnt, 1);
        check_eq({tag, " error"}, done_err, want_tmo);
        check_eq({tag, " busy with done"}, done_busy_bad, 0);
        check_eq({tag, " busy after"}, bus.busy, 0);
        if (want_tmo) begin
            check_eq({tag, " timeout window"},
                     (done_cyc - hold_cyc == TIMEOUT) || (done_cyc - hold_cyc == TIMEOUT + 1), 1);
            check_eq({tag, " ops before abort"}, op_cnt, hold_idx + 1);
        end else begin
            check_eq({tag, " sq_cnt"}, bus.sq_cnt, msb);
            check_eq({tag, " mul_cnt"}, bus.mul_cnt, $countones(e));
            check_eq({tag, " op count"}, op_log.size(), want_ops.size());
            for (int i = 0; i < want_ops.size() && i < op_log.size(); i++)
                check_eq($sformatf("%s op%0d", tag, i), op_log[i], want_ops[i]);
            check_eq({tag, " one done per start"}, resp_cnt, op_cnt);
            check_eq({tag, " select stability"}, sel_bad, 0);
            check_eq({tag, " overlapping start"}, multi_bad, 0);
            check_eq({tag, " result"}, acc, ref_modexp(x_val, e));
        end
    endtask

    initial begin
        logic [EXP_BITS-1:0] e;
        logic [IDX_W:0]      sq_prev, mul_prev;
        int                  ops_prev, pre_prev, k;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.exp   = '0;
        op_cnt = 0; resp_cnt = 0; done_cnt = 0; pre_issues = 0; hold_cyc = 0; done_cyc = 0;
        #12;
        check_eq("reset outputs",
                 {bus.busy, bus.done, bus.error, bus.pre_start, bus.mm_start,
                  bus.mm_opa_sel, bus.mm_opb_sel, bus.mm_dst_sel, bus.sq_cnt, bus.mul_cnt}, 0);
        @(negedge clk);
        rst = 1'b0;

        e = '0; e[3:0] = 4'b1011;
        run_case("exp_1011", e, 1'b0, 1'b0);
        run_case("exp_zero", '0, 1'b0, 1'b0);
        check_eq("exp_zero acc is one", acc, 64'd1);
        run_case("exp_ones", {EXP_BITS{1'b1}}, 1'b0, 1'b0);

        hold_idx = 2;
        e = '0; e[9:0] = 10'($urandom) | 10'h200;
        run_case("timeout", e, 1'b1, 1'b0);
        hold_idx = -1;
        run_case("after_timeout", e, 1'b0, 1'b0);

        lat_min = 1; lat_max = 50;
        e = '0; e[11:0] = 12'($urandom) | 12'h800;
        run_case("restart_ignored", e, 1'b0, 1'b1);

        sq_prev  = bus.sq_cnt;
        mul_prev = bus.mul_cnt;
        ops_prev = op_cnt;
        pre_prev = pre_issues;
        done_cnt = 0;
        @(negedge clk);
        stray_mm  = 1'b1;
        stray_pre = 1'b1;
        @(negedge clk);
        stray_mm  = 1'b0;
        stray_pre = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("stray sq_cnt", bus.sq_cnt, sq_prev);
        check_eq("stray mul_cnt", bus.mul_cnt, mul_prev);
        check_eq("stray no activity", {bus.busy, 32'(op_cnt - ops_prev), 32'(pre_issues - pre_prev), 32'(done_cnt)}, 0);

        for (int r = 0; r < 4; r++) begin
            e = '0;
            e[11:0] = 12'($urandom);
            if (r == 3) e[EXP_BITS-1] = 1'b1;
            if (r == 3) lat_max = 3;
            run_case($sformatf("random%0d", r), e, 1'b0, 1'b0);
        end

        lat_min = 5; lat_max = 5;
        clear_model();
        e = '0; e[3:0] = 4'b1010;
        @(negedge clk);
        bus.start = 1'b1;
        bus.exp   = e;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (!(pend && op_log.size() > 0 && op_log[op_log.size()-1] == OPC_SQ) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check_eq("reached SQ wait", k < 5000, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async reset outputs",
                 {bus.busy, bus.done, bus.error, bus.pre_start, bus.mm_start,
                  bus.mm_opa_sel, bus.mm_opb_sel, bus.mm_dst_sel, bus.sq_cnt, bus.mul_cnt}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (30) @(negedge clk);
        check_eq("no done after reset", done_cnt, 0);
        check_eq("idle after reset", {bus.busy, bus.mm_start, bus.pre_start}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
